// File: rtl/rx_pattern_checker.sv
// rx_pattern_checker
//   Consumes the 2-lane loopback stream generated from the 00,01,10,11
//   pattern sequencer. It hunts for the incrementing 2-bit pattern, declares
//   lock after LOCK_CNT consecutive matches, and then counts received symbols
//   and per-lane bit errors. It drops back to hunting after UNLOCK_ERR
//   consecutive errored symbols.
//
// Ports
//   RSTX       in   async reset, active-low
//   CLK        in   clock, rising edge
//   CLR        in   synchronous clear of counters and FSM (ignores EN)
//   EN         in   checker enable; when low, all state is held
//   DIN_VLD    in   DIN carries a valid symbol this cycle
//   DIN[1:0]   in   received symbol, bit k = lane k
//   LOCKED     out  high while in LOCK
//   ERR_PULSE  out  one-cycle pulse per errored symbol counted in LOCK
//   RECV_CNT   out  symbols checked while locked (saturating)
//   ERR_CNT    out  {lane1 errors, lane0 errors} (each saturating)
module rx_pattern_checker #(
    parameter int RECV_W     = 60,
    parameter int ERR_W      = 32,
    parameter int LOCK_CNT   = 8,
    parameter int UNLOCK_ERR = 4
) (
    input  logic                 RSTX,
    input  logic                 CLK,
    input  logic                 CLR,
    input  logic                 EN,
    input  logic                 DIN_VLD,
    input  logic [1:0]           DIN,
    output logic                 LOCKED,
    output logic                 ERR_PULSE,
    output logic [RECV_W-1:0]    RECV_CNT,
    output logic [2*ERR_W-1:0]   ERR_CNT
);

    localparam logic [1:0] ST_HUNT = 2'd0;
    localparam logic [1:0] ST_SYNC = 2'd1;
    localparam logic [1:0] ST_LOCK = 2'd2;

    localparam logic [7:0] LOCK_CNT_V   = 8'(LOCK_CNT);
    localparam logic [7:0] UNLOCK_ERR_V = 8'(UNLOCK_ERR);

    logic [1:0]        r_state;
    logic [1:0]        r_exp;
    logic [7:0]        r_good_cnt;
    logic [7:0]        r_bad_run;
    logic              r_err_pulse;
    logic [RECV_W-1:0] r_recv_cnt;
    logic [ERR_W-1:0]  r_err0;
    logic [ERR_W-1:0]  r_err1;

    logic              w_sample;
    logic [1:0]        w_lane_err;
    logic [7:0]        w_good_nxt;
    logic [7:0]        w_bad_nxt;

    assign w_sample   = EN & DIN_VLD;
    assign w_lane_err = DIN ^ r_exp;
    assign w_good_nxt = r_good_cnt + 8'd1;
    assign w_bad_nxt  = r_bad_run + 8'd1;

    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            r_state     <= ST_HUNT;
            r_exp       <= '0;
            r_good_cnt  <= '0;
            r_bad_run   <= '0;
            r_err_pulse <= 1'b0;
            r_recv_cnt  <= '0;
            r_err0      <= '0;
            r_err1      <= '0;
        end else if (CLR) begin
            r_state     <= ST_HUNT;
            r_exp       <= '0;
            r_good_cnt  <= '0;
            r_bad_run   <= '0;
            r_err_pulse <= 1'b0;
            r_recv_cnt  <= '0;
            r_err0      <= '0;
            r_err1      <= '0;
        end else begin
            r_err_pulse <= 1'b0;
            if (w_sample) begin
                case (r_state)
                    ST_HUNT: begin
                        r_exp      <= DIN + 2'd1;
                        r_good_cnt <= 8'd1;
                        r_state    <= ST_SYNC;
                    end
                    ST_SYNC: begin
                        if (DIN == r_exp) begin
                            r_exp      <= r_exp + 2'd1;
                            r_good_cnt <= w_good_nxt;
                            if (w_good_nxt == LOCK_CNT_V) begin
                                r_state   <= ST_LOCK;
                                r_bad_run <= '0;
                            end
                        end else begin
                            // Mismatch reseeds from this symbol; it counts as the first good one.
                            r_exp      <= DIN + 2'd1;
                            r_good_cnt <= 8'd1;
                        end
                    end
                    ST_LOCK: begin
                        r_exp <= r_exp + 2'd1;
                        if (r_recv_cnt != '1) r_recv_cnt <= r_recv_cnt + 1'b1;
                        if (w_lane_err[0] && (r_err0 != '1)) r_err0 <= r_err0 + 1'b1;
                        if (w_lane_err[1] && (r_err1 != '1)) r_err1 <= r_err1 + 1'b1;
                        if (|w_lane_err) begin
                            r_err_pulse <= 1'b1;
                            r_bad_run   <= w_bad_nxt;
                            if (w_bad_nxt == UNLOCK_ERR_V) r_state <= ST_HUNT;
                        end else begin
                            r_bad_run <= '0;
                        end
                    end
                    default: r_state <= ST_HUNT;
                endcase
            end
        end
    end

    assign LOCKED    = (r_state == ST_LOCK);
    assign ERR_PULSE = r_err_pulse;
    assign RECV_CNT  = r_recv_cnt;
    assign ERR_CNT   = {r_err1, r_err0};

endmodule

// File: doc/rx_pattern_checker.md
Name: rx_pattern_checker

Overview:
- Downstream consumer of the loopback data produced by the stimulus stage (2-lane DIN driven from the 00,01,10,11 pattern sequencer).
- Aligns to the incrementing 2-bit pattern, declares lock, then counts received symbols and per-lane bit errors.
- Its count outputs feed the stimulus-stage RECV_CNT/ERR_CNT reporting ports.

Parameters:
- RECV_W, 60: width of received-symbol counter.
- ERR_W, 32: width of each per-lane error counter.
- LOCK_CNT, 8: consecutive matching symbols required to enter LOCK (legal range 2..255).
- UNLOCK_ERR, 4: consecutive errored symbols in LOCK that force HUNT (legal range 1..255).

Ports:
- RSTX  input  1  asynchronous reset, active-low.
- CLK  input  1  clock; all logic rising-edge.
- CLR  input  1  synchronous clear of counters and FSM.
- EN  input  1  checker enable; when low, samples are ignored and all state is held.
- DIN_VLD  input  1  DIN carries a valid symbol this cycle.
- DIN  input  2  received symbol; bit k is lane k.
- LOCKED  output  1  high while FSM is in LOCK (registered).
- ERR_PULSE  output  1  one-cycle pulse per errored symbol counted in LOCK.
- RECV_CNT  output  RECV_W  symbols checked while locked.
- ERR_CNT  output  2*ERR_W  {lane1 errors, lane0 errors}.

Behaviour:
- Reset (RSTX low, async):
  - FSM = HUNT; exp = 0; good_cnt = 0; bad_run = 0.
  - LOCKED = 0, ERR_PULSE = 0, RECV_CNT = 0, ERR_CNT = 0.
- "Sample" means a cycle with EN=1 and DIN_VLD=1. All other cycles change nothing, except that ERR_PULSE returns to 0.
- Expected pattern: exp advances by 1 modulo 4 on every sample (3 -> 0 wrap).
- HUNT:
  - On a sample: exp <= DIN+1, good_cnt <= 1, go to SYNC.
- SYNC:
  - Sample with DIN == exp: good_cnt++, exp++.
  - If the incremented good_cnt == LOCK_CNT: go to LOCK, bad_run <= 0.
  - Sample with DIN != exp: reseed exp <= DIN+1, good_cnt <= 1, stay in SYNC.
  - No counter updates in HUNT or SYNC.
  - The sample that completes lock is not counted.
- LOCK:
  - Every sample: RECV_CNT++, saturating at all-ones.
  - Per lane k: if DIN[k] != exp[k], that lane's ERR_CNT++, saturating at all-ones; lanes are independent.
  - exp always advances; it is never reseeded in LOCK.
  - Sample with any lane error: ERR_PULSE <= 1, bad_run++. If the incremented bad_run == UNLOCK_ERR, go to HUNT. RECV_CNT and ERR_CNT are still updated for that sample.
  - Clean sample: bad_run <= 0.
- Timing and latency:
  - All outputs are registered; counters, ERR_PULSE and LOCKED reflect a sample on the cycle after it is presented.
  - LOCKED rises the cycle after the LOCK_CNT-th good sample.
  - LOCKED falls the cycle after the UNLOCK_ERR-th consecutive bad sample.
- Counters are not cleared on lock or unlock; only CLR and RSTX clear them.
- CLR = 1:
  - Next cycle: FSM = HUNT, exp = 0, good_cnt = 0, bad_run = 0, counters = 0, ERR_PULSE = 0.
  - CLR overrides a simultaneous sample, which is discarded.
  - CLR takes effect regardless of EN.
- EN falling mid-lock: FSM stays in LOCK, exp is frozen, counters are held. Checking resumes on the next sample with no realignment.
- Saturation: a saturated counter stays at all-ones; other counters keep counting.
- Reset mid-operation: immediate async return to the reset values above.

Test Plan:
- Clean stream 0,1,2,3,0,... with DIN_VLD every cycle → LOCKED = 1 the cycle after sample 8. Then 100 further samples → RECV_CNT = 100, ERR_CNT = 0.
- In LOCK, one symbol 2 replaced by 3 (lane0 bit flipped) → ERR_CNT lane0 = 1, lane1 = 0; single ERR_PULSE; LOCKED stays 1.
- In LOCK, 4 consecutive symbols inverted (DIN = ~exp) → both lanes +4, RECV_CNT +4, LOCKED = 0 the next cycle. Resume the clean stream → relock after 8 further samples.
- In SYNC after 5 good samples, inject 0 where 2 was expected → good_cnt restarts from that sample. LOCKED rises only after 7 more matching samples; RECV_CNT stays 0 throughout.
- EN low for 10 cycles with DIN_VLD toggling, then clean continuation → counters frozen during the gap, no errors when resuming. CLR asserted together with a sample → all counters 0, LOCKED = 0, FSM in HUNT.
- With RECV_W forced to 4: 20 clean locked samples → RECV_CNT = 15 (saturated). With ERR_W = 2: 5 lane1 errors → ERR_CNT lane1 = 3. RSTX pulse mid-LOCK → all outputs 0 immediately.
